// File: rtl/polarity_debounce.sv
// WIDTH-channel synchroniser + debouncer with a run-time polarity mask on the output.
// Optional rise/fall pulses on filtered transitions: define POLARITY_DEBOUNCE_EDGE_EN.

module polarity_debounce_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit INIT_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic a_i,
  input  logic invert_i,
  output logic y_o,
  output logic busy_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   filt_q, filt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   y_q, busy_q;

  assign s = sync_q[SYNC_STAGES-1];

  // Any cycle agreeing with the filtered level restarts the persistence count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (s == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      filt_d = s;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= {SYNC_STAGES{INIT_LEVEL}};
      filt_q <= INIT_LEVEL;
      cnt_q  <= '0;
      y_q    <= INIT_LEVEL;
      busy_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], a_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      y_q    <= filt_d ^ invert_i;
      busy_q <= (cnt_d != '0);
    end
  end

  assign y_o    = y_q;
  assign busy_o = busy_q;

`ifdef POLARITY_DEBOUNCE_EDGE_EN
  // Edges are taken before inversion so mask changes never pulse.
  logic rise_q, fall_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= filt_d & ~filt_q;
      fall_q <= ~filt_d & filt_q;
    end
  end
  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

module polarity_debounce #(
  parameter int WIDTH           = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit INIT_LEVEL      = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] invert,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] busy,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    polarity_debounce_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT_LEVEL     (INIT_LEVEL)
    ) u_lane (
      .clk     (clk),
      .resetn  (resetn),
      .a_i     (a[i]),
      .invert_i(invert[i]),
      .y_o     (y[i]),
      .busy_o  (busy[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i])
    );
  end

endmodule
